// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store controller with RMW for sub-word stores
module mem_access_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-3:0] data_addr,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData
);
    typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, RESP} state_t;
    state_t state_q, state_d;
    logic write_q, write_d, signed_q, signed_d;
    logic [1:0] size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d, write_data_q, write_data_d;
    logic [ADDR_W-3:0] data_addr_q, data_addr_d;
    logic accept, err;
    logic [4:0] sh;
    logic [DATA_W-1:0] mask, merged, lane, load_data;
    always_comb begin
        accept = state_q == IDLE && req_ready_q && req_valid;
        err = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
        sh = size_q == 2'd0 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
        mask = (size_q == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        merged = (readData & ~mask) | ((wdata_q << sh) & mask);
        lane = readData >> sh;
        load_data = size_q == 2'd2 ? readData :
                    size_q == 2'd0 ? {{24{signed_q & lane[7]}}, lane[7:0]} :
                                     {{16{signed_q & lane[15]}}, lane[15:0]};
        state_d = state_q;
        write_d = write_q;
        size_d = size_q;
        signed_d = signed_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d = resp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                write_d = req_write;
                size_d = req_size;
                signed_d = req_signed;
                addr_d = req_addr;
                wdata_d = req_wdata;
                state_d = err ? RESP : (req_write && req_size == 2'd2) ? WRITE : READ;
                resp_err_d = err ? 1'b1 : resp_err_q;
                resp_rdata_d = err ? '0 : resp_rdata_q;
            end
            READ: state_d = RWAIT;
            RWAIT: begin
                state_d = write_q ? WRITE : RESP;
                resp_rdata_d = write_q ? resp_rdata_q : load_data;
                resp_err_d = write_q ? resp_err_q : 1'b0;
            end
            WRITE: begin
                state_d = RESP;
                resp_rdata_d = '0;
                resp_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Strobes and pins are registered from the next state so they are clean for the whole state
        req_ready_d = state_d == IDLE;
        resp_valid_d = state_d == RESP;
        mem_read_d = state_d == READ;
        mem_write_d = state_d == WRITE;
        data_addr_d = (state_d == READ || state_d == WRITE) ? addr_d[ADDR_W-1:2] : '0;
        write_data_d = state_d == WRITE ? (state_q == IDLE ? req_wdata : merged) : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q <= 2'd0;
            signed_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            req_ready_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q <= 1'b0;
            mem_write_q <= 1'b0;
            data_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q <= size_d;
            signed_q <= signed_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            req_ready_q <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q <= mem_read_d;
            mem_write_q <= mem_write_d;
            data_addr_q <= data_addr_d;
            write_data_q <= write_data_d;
        end
    end
    assign req_ready = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign memRead = mem_read_q;
    assign memWrite = mem_write_q;
    assign data_addr = data_addr_q;
    assign writeData = write_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, reset abort sequence and random back-to-back traffic vs a byte-level model
module tb_mem_access_unit;
    logic clk = 0, rst_n = 0, req_valid = 0, req_ready, req_write = 0, req_signed = 0;
    logic [1:0] req_size = 0;
    logic [11:0] req_addr = 0;
    logic [31:0] req_wdata = 0, resp_rdata, writeData, readData;
    logic resp_valid, resp_err, memRead, memWrite;
    logic [9:0] data_addr;
    logic [31:0] mem [1024];
    logic [7:0] refm [4096];
    int checks = 0, failures = 0, overlap = 0;

    typedef struct {
        logic w; logic [1:0] sz; logic sg; logic [11:0] a; logic [31:0] wd;
        logic [31:0] rd; logic e; int lat;
    } vec_t;

    mem_access_unit dut (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .memRead(memRead), .memWrite(memWrite), .data_addr(data_addr), .writeData(writeData),
        .readData(readData));

    always #5 clk = ~clk;

    // data memory with one-cycle registered read
    always @(posedge clk) begin
        if (memWrite) mem[data_addr] <= writeData;
        if (memRead) readData <= mem[data_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".flags"}, {27'd0, req_ready, resp_valid, resp_err, memRead, memWrite}, 0);
        chk({tag, ".rdata"}, resp_rdata, 0);
        chk({tag, ".addr"}, {22'd0, data_addr}, 0);
        chk({tag, ".wdata"}, writeData, 0);
    endtask

    // Reference: byte-addressed memory, response/latency straight from the access rules
    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [11:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat,
                         output int enr, output int enw, output logic [31:0] eword);
        int n, wa;
        logic [31:0] v;
        e = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
        rd = 0; eword = 0; enr = 0; enw = 0; lat = 1;
        n = 1 << sz;
        wa = int'(a) / 4;
        if (!e && !w) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (32'(refm[int'(a) + i]) << (8 * i));
            if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v; lat = 3; enr = 1;
        end else if (!e) begin
            for (int i = 0; i < n; i++) refm[int'(a) + i] = wd[8 * i +: 8];
            lat = n == 4 ? 2 : 4; enr = n == 4 ? 0 : 1; enw = 1;
            eword = {refm[wa * 4 + 3], refm[wa * 4 + 2], refm[wa * 4 + 1], refm[wa * 4]};
        end
    endtask

    task automatic do_req(input vec_t v, input logic hold, output int waited, output int lat,
                          output logic [31:0] rd, output logic e, output int nr, output int nw,
                          output int wcyc, output logic [9:0] wad, output logic [31:0] wdt);
        req_valid = 1; req_write = v.w; req_size = v.sz; req_signed = v.sg; req_addr = v.a; req_wdata = v.wd;
        waited = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        req_valid = hold; req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = 12'($urandom); req_wdata = $urandom;
        nr = 0; nw = 0; wcyc = 0; wad = 0; wdt = 0; lat = 1;
        forever begin
            if (memRead && memWrite) overlap++;
            if (memRead) nr++;
            if (memWrite) begin
                nw++; wcyc = lat; wad = data_addr; wdt = writeData;
            end
            if (resp_valid || lat >= 12) break;
            tick();
            lat++;
        end
        rd = resp_rdata; e = resp_err;
    endtask

    task automatic run(input string tag, input vec_t v, input bit use_tbl, input logic hold, input bit b2b);
        logic [31:0] m_rd, m_word, rd, wdt;
        logic m_e, e;
        logic [9:0] wad;
        int m_lat, m_nr, m_nw, waited, lat, nr, nw, wcyc;
        model(v.w, v.sz, v.sg, v.a, v.wd, m_rd, m_e, m_lat, m_nr, m_nw, m_word);
        do_req(v, hold, waited, lat, rd, e, nr, nw, wcyc, wad, wdt);
        chk({tag, ".rdata"}, rd, use_tbl ? v.rd : m_rd);
        chk({tag, ".err"}, {31'd0, e}, {31'd0, use_tbl ? v.e : m_e});
        chk({tag, ".lat"}, lat, use_tbl ? v.lat : m_lat);
        chk({tag, ".reads"}, nr, m_nr);
        chk({tag, ".writes"}, nw, m_nw);
        if (m_nw == 1) begin
            chk({tag, ".wcyc"}, wcyc, m_lat - 1);
            chk({tag, ".waddr"}, {22'd0, wad}, {22'd0, v.a[11:2]});
            chk({tag, ".wword"}, wdt, m_word);
        end
        if (b2b) chk({tag, ".b2b_wait"}, waited, 1);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [31:0] held;
        int bad, r;
        for (int w = 0; w < 1024; w++) begin
            logic [31:0] x;
            x = $urandom;
            mem[w] <= x;
            for (int k = 0; k < 4; k++) refm[4 * w + k] = x[8 * k +: 8];
        end
        tbl.push_back('{1, 2, 0, 12'h010, 32'hDEADBEEF, 0, 0, 2});
        tbl.push_back('{0, 2, 0, 12'h010, 0, 32'hDEADBEEF, 0, 3});
        tbl.push_back('{1, 2, 0, 12'h020, 32'h80FF7F01, 0, 0, 2});
        tbl.push_back('{0, 0, 1, 12'h021, 0, 32'h0000007F, 0, 3});
        tbl.push_back('{0, 0, 1, 12'h023, 0, 32'hFFFFFF80, 0, 3});
        tbl.push_back('{0, 1, 0, 12'h022, 0, 32'h000080FF, 0, 3});
        tbl.push_back('{0, 1, 1, 12'h022, 0, 32'hFFFF80FF, 0, 3});
        tbl.push_back('{1, 2, 0, 12'h020, 32'h11223344, 0, 0, 2});
        tbl.push_back('{1, 0, 0, 12'h022, 32'hFFFFFFAB, 0, 0, 4});
        tbl.push_back('{0, 2, 0, 12'h020, 0, 32'h11AB3344, 0, 3});
        tbl.push_back('{0, 2, 0, 12'h006, 0, 0, 1, 1});
        tbl.push_back('{1, 1, 0, 12'h003, 32'h00005555, 0, 1, 1});
        tbl.push_back('{0, 3, 0, 12'h040, 0, 0, 1, 1});
        tbl.push_back('{1, 2, 0, 12'hFFC, 32'h01020304, 0, 0, 2});
        tbl.push_back('{1, 0, 0, 12'hFFF, 32'h123456A5, 0, 0, 4});
        tbl.push_back('{0, 2, 0, 12'hFFC, 0, 32'hA5020304, 0, 3});
        tbl.push_back('{0, 0, 0, 12'hFFF, 0, 32'h000000A5, 0, 3});
        tbl.push_back('{1, 1, 0, 12'h012, 32'h00001234, 0, 0, 4});
        tbl.push_back('{0, 2, 0, 12'h010, 0, 32'h1234BEEF, 0, 3});
        tbl.push_back('{0, 1, 1, 12'h010, 0, 32'hFFFFBEEF, 0, 3});

        tick();
        tick();
        chk_zero("reset");
        rst_n = 1;
        chk("ready_low_first", {31'd0, req_ready}, 0);
        tick();
        chk("ready_rise", {31'd0, req_ready}, 1);

        foreach (tbl[i]) begin
            run($sformatf("vec%0d", i), tbl[i], 1, 0, 0);
            held = resp_rdata;
            tick();
            chk($sformatf("vec%0d.idle_flags", i), {28'd0, resp_valid, memRead, memWrite, req_ready}, 1);
            chk($sformatf("vec%0d.hold", i), resp_rdata, tbl[i].rd);
            chk($sformatf("vec%0d.idle_addr", i), {22'd0, data_addr}, 0);
            chk($sformatf("vec%0d.idle_wdata", i), writeData, 0);
        end

        // reset while a halfword RMW sits in RWAIT
        run("rst_pre", '{1, 2, 0, 12'h030, 32'hCAFEF00D, 0, 0, 2}, 1, 0, 0);
        tick();
        req_valid = 1; req_write = 1; req_size = 1; req_signed = 0; req_addr = 12'h032; req_wdata = 32'h1234;
        tick();
        req_valid = 0;
        chk("rst_read", {31'd0, memRead}, 1);
        tick();
        rst_n = 0;
        tick();
        chk_zero("rst_abort");
        rst_n = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (memWrite || resp_valid || memRead) bad++;
        end
        chk("rst_no_activity", bad, 0);
        chk("rst_ready", {31'd0, req_ready}, 1);
        chk("rst_mem_kept", mem[12], 32'hCAFEF00D);
        run("rst_post", '{0, 2, 0, 12'h030, 0, 32'hCAFEF00D, 0, 3}, 1, 0, 0);
        tick();

        // back-to-back random traffic with req_valid held high
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            v.w = i[0];
            v.sz = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
            v.sg = 1'($urandom);
            v.a = 12'h100 + 12'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0 && v.sz != 3) v.a = v.a & ~((12'd1 << v.sz) - 12'd1);
            v.wd = $urandom;
            v.rd = 0; v.e = 0; v.lat = 0;
            run($sformatf("rnd%0d", i), v, 0, 1, i > 0);
        end
        req_valid = 0;
        tick();
        tick();

        chk("strobe_overlap", overlap, 0);
        bad = 0;
        for (int w = 0; w < 1024; w++)
            if (mem[w] !== {refm[4 * w + 3], refm[4 * w + 2], refm[4 * w + 1], refm[4 * w]}) bad++;
        chk("mem_final", bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store controller that initiates every access to the data memory block. Accepts one byte/halfword/word request at a time from the execute stage over a valid/ready handshake, drives the memory's `memRead`/`memWrite`/`data_addr`/`writeData` pins, absorbs the memory's one-cycle registered read latency, and returns formatted load data. Sub-word stores use read-modify-write because the memory has a single whole-word write enable.

## Interface
Parameters:
- `ADDR_W`, 12: byte-address width; word address is `ADDR_W-2` = 10 bits.
- `DATA_W`, 32: data width; fixed at 32.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend sub-word loads (ignored for stores and word loads).
- `req_addr` in 12: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: formatted load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; misaligned or illegal size.
- `memRead` out 1, `memWrite` out 1, `data_addr` out 10, `writeData` out 32: to data memory.
- `readData` in 32: from data memory; valid the cycle after the address is presented with `memRead`.

## Operation
- States: IDLE, READ, RWAIT, WRITE, RESP.
- IDLE: `req_ready`=1. Transfer on `req_valid && req_ready`; latch write, size, signed, address, wdata.
- Error check at accept: size 11, halfword with `addr[0]`=1, or word with `addr[1:0]`≠0 → RESP with `resp_err`=1. No memory pins asserted.
- Load → READ. Word store → WRITE. Byte/halfword store → READ (RMW).
- READ: `memRead`=1 and `data_addr`=`addr[11:2]` for exactly one cycle → RWAIT.
- RWAIT: `readData` sampled at the end of the cycle.
  - Load: extract lane, then go to RESP.
  - RMW: merge store bytes into the read word, then go to WRITE.
- Lanes are little-endian:
  - Byte lane is `addr[1:0]` (bits `8*k+7:8*k`).
  - Halfword lane is `addr[1]`.
  - Sign-extend when `req_signed`=1, else zero-extend.
- WRITE: `memWrite`=1, `data_addr` = word address, `writeData` = full word (req_wdata or merged word) for exactly one cycle → RESP.
- RESP: `resp_valid`=1 for one cycle → IDLE. `resp_rdata`/`resp_err` hold their values until the next RESP.
- `memRead` and `memWrite` are never high together.
- `data_addr`/`writeData` come from registers: stable for the entire state in which the strobe is high; 0 in IDLE.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE).

## Timing
- Cycle 0 is the accept edge. `resp_valid` is high in cycle:
  - word store 2;
  - load 3;
  - sub-word store 4;
  - error 1.
- Throughput: one request per (latency+1) cycles; no overlap.
- Reset (`rst_n`=0 at a rising edge):
  - state IDLE; all outputs 0, including `req_ready`, `resp_*`, `memRead`, `memWrite`, `data_addr`, `writeData`.
  - `req_ready` rises the first cycle after `rst_n` returns high.
- Reset mid-operation aborts the request with no response.
  - Reset during READ/RWAIT of an RMW: no write ever issues.
  - Reset during WRITE: `memWrite` is 0 from the next cycle. A write already sampled at that edge is not undone.
- `req_*` inputs are ignored outside IDLE. The bench may change them freely there.
- Address wrap: `addr` 0xFFF byte store → word 0x3FF, lane 3; no carry.

## Test plan
- Word store 0xDEADBEEF @0x010 then word load @0x010:
  - `memWrite` pulse in cycle 1 with `data_addr`=0x004;
  - store response in cycle 2;
  - load `resp_rdata`=0xDEADBEEF in cycle 3, err=0.
- Word @0x020 = 0x80FF7F01. Signed byte loads @0x021 and @0x023 → 0x0000007F and 0xFFFFFF80. Unsigned half load @0x022 → 0x000080FF. Signed half load @0x022 → 0xFFFF80FF.
- Byte store 0xAB @0x022 over word 0x11223344:
  - READ then WRITE of 0x11AB3344 to word 0x008;
  - `resp_valid` in cycle 4;
  - other bytes unchanged.
- Misaligned word load @0x006, half store @0x003, and size 11:
  - each gives `resp_err`=1 in cycle 1;
  - `memRead`/`memWrite` never asserted;
  - memory contents unchanged.
- `rst_n` low during RWAIT of a half-store RMW: no `memWrite` pulse, no `resp_valid`, all outputs 0, target word unchanged. A fresh request after reset completes normally.
- `req_valid` held high with alternating loads/stores for 20 requests:
  - each accepted only when `req_ready`=1, in the cycle after the previous RESP;
  - strobes never overlap;
  - every response matches a reference model.
